boot_memory: RTL and testbench
==============================

Name: boot_memory

Overview:
- Unified 256x8 program/data memory on the CPU memory port. It serves memAdr/memWD/memEnable from the CPU and returns memRD.
- Contains a byte-stream boot loader FSM. The loader fills RAM from an external valid/ready source while holding the CPU in reset via cpuReset, then releases it.
- Adds one memory-mapped input register and one memory-mapped output register, so programs can do I/O without a separate bus.

Parameters:
- PROG_LEN, 256: bytes accepted before loading ends automatically (1..256).
- IN_ADDR, 8'hFE: read address mapped to the synchronized inPort.
- OUT_ADDR, 8'hFF: write address that also updates outPort.
- SKIP_LOAD, 0: when 1, reset goes straight to RUN and the loader is never used.

Ports:
- clk  in  1  system clock, all logic on the rising edge
- reset  in  1  synchronous, active-high reset
- memEnable  in  1  CPU write enable
- memAdr  in  8  CPU byte address
- memWD  in  8  CPU write data
- memRD  out  8  CPU read data (combinational)
- loadValid  in  1  loader byte valid
- loadData  in  8  loader byte
- loadDone  in  1  early end-of-program strobe
- loadReady  out  1  loader can accept a byte
- cpuReset  out  1  reset to the CPU core
- loadCount  out  9  bytes accepted in the current load
- inPort  in  8  asynchronous external input
- outPort  out  8  registered external output

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values:
  - state = LOAD, or RUN when SKIP_LOAD=1.
  - loadCount = 0, outPort = 0, input synchronizer flops = 0.
  - cpuReset = 1, loadReady = 0 during the reset cycle.
  - RAM contents are not cleared by reset.
- States: LOAD, RELEASE, RUN.
- LOAD:
  - loadReady = 1, cpuReset = 1.
  - Handshake: a byte transfers on a cycle with loadValid && loadReady. RAM[loadCount[7:0]] <= loadData, and loadCount increments.
  - Go to RELEASE when the accepted byte makes loadCount == PROG_LEN. Also go to RELEASE on loadDone.
  - loadDone and loadValid asserted in the same cycle: the byte is written first, then the FSM goes to RELEASE.
  - loadDone alone with loadCount == 0 also goes to RELEASE, leaving an empty load and old RAM contents intact.
  - CPU writes (memEnable) are ignored in LOAD. memRD still reflects memAdr.
- RELEASE:
  - Lasts exactly one cycle.
  - loadReady = 0, cpuReset = 1.
  - Gives the CPU one reset edge after the final byte, then the FSM goes to RUN.
- RUN:
  - cpuReset = 0, loadReady = 0.
  - loadValid and loadDone are ignored.
  - loadCount holds its final value.
- CPU write in RUN: a cycle with memEnable writes RAM[memAdr] <= memWD on the clock edge. If memAdr == OUT_ADDR, outPort <= memWD on the same edge, and RAM is written too.
- Read path: memRD = sync2 when memAdr == IN_ADDR, otherwise RAM[memAdr]. sync2 is the second flop of a 2-flop synchronizer on inPort.
- Read latency:
  - memRD is zero-latency combinational, as required by the multicycle fetch/load timing.
  - A read of an address in the same cycle as a write returns the old data.
  - The new data is visible from the next cycle.
- Input latency: a change on inPort is visible on memRD (at IN_ADDR) 2 edges later.
- Wrap-around: loadCount is 9 bits. Address 255 is written by byte 256 with PROG_LEN=256, and loadCount reads 256 in RUN. No write ever goes past address 255.
- Reset mid-operation:
  - In any state, reset returns the FSM to LOAD (or RUN if SKIP_LOAD=1), clears loadCount and outPort, and asserts cpuReset.
  - A partially loaded image remains in RAM and is overwritten from address 0 by the next load.
- cpuReset is driven from a register decoded from state only, so it is glitch-free.

Test Plan:
1. Reset, PROG_LEN=4, stream 8'h11,22,33,44 with loadValid gapped every other cycle -> loadReady=1 throughout LOAD; loadCount 1..4; cpuReset=1 through LOAD and the single RELEASE cycle, 0 from the following cycle; memRD at addresses 0..3 = 11,22,33,44.
2. Mid-load, PROG_LEN=256, loadValid with 8'hAA together with loadDone at loadCount=2 -> RAM[2]=AA, loadCount=3, RELEASE next cycle, then RUN.
3. RUN, memEnable with memAdr=8'hFF, memWD=8'h5C -> outPort=5C after the edge, RAM[FF]=5C. The same-cycle read of FF returns the old value; the next cycle returns 5C.
4. inPort changes 00->9E while memAdr=FE -> memRD still 00 for one edge, 9E after the second edge.
5. memEnable asserted during LOAD at address 10 with 8'h77 -> RAM[10] unchanged. Then reset asserted in RUN -> cpuReset=1, outPort=0, loadCount=0, loadReady=1, RAM contents preserved.
6. PROG_LEN=256 full load -> final byte lands at address 255, loadCount=256, automatic RELEASE, no write to address 0 afterwards.

Source files
------------

// File: rtl/boot_memory_if.sv
// CPU memory port and loader byte-stream handshake shared by boot_memory and its master.
interface boot_memory_if;
    logic       memEnable;
    logic [7:0] memAdr;
    logic [7:0] memWD;
    logic [7:0] memRD;
    logic       loadValid;
    logic [7:0] loadData;
    logic       loadDone;
    logic       loadReady;

    modport master (
        output memEnable, memAdr, memWD, loadValid, loadData, loadDone,
        input  memRD, loadReady
    );

    modport slave (
        input  memEnable, memAdr, memWD, loadValid, loadData, loadDone,
        output memRD, loadReady
    );
endinterface

// File: rtl/boot_memory.sv
// Unified 256x8 program/data RAM with a boot loader that holds the CPU in reset,
// plus one memory-mapped input register and one memory-mapped output register.
module boot_memory #(
    parameter int         PROG_LEN  = 256,
    parameter logic [7:0] IN_ADDR   = 8'hFE,
    parameter logic [7:0] OUT_ADDR  = 8'hFF,
    parameter bit         SKIP_LOAD = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    boot_memory_if.slave      bus,
    output logic              cpuReset,
    output logic [8:0]        loadCount,
    input  logic [7:0]        inPort,
    output logic [7:0]        outPort
);

    localparam logic [1:0] S_LOAD    = 2'd0;
    localparam logic [1:0] S_RELEASE = 2'd1;
    localparam logic [1:0] S_RUN     = 2'd2;
    localparam logic [1:0] S_INIT    = SKIP_LOAD ? S_RUN : S_LOAD;
    localparam logic [8:0] LAST      = 9'(PROG_LEN);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [7:0] ram [256];
    logic [7:0] in_sync_p1;
    logic [7:0] in_sync_p2;
    logic       cpu_rst_q;
    logic       load_acc;
    logic       cpu_wr;
    logic [8:0] count_inc;

    // Ready is masked during reset so no byte can slip in on the reset edge.
    assign bus.loadReady = (state == S_LOAD) && !reset;
    assign load_acc      = bus.loadValid && bus.loadReady;
    assign cpu_wr        = (state == S_RUN) && bus.memEnable && !reset;
    assign count_inc     = loadCount + 9'd1;

    always_comb begin
        state_nxt = state;
        case (state)
            S_LOAD:    if ((load_acc && (count_inc == LAST)) || bus.loadDone)
                           state_nxt = S_RELEASE;
            S_RELEASE: state_nxt = S_RUN;
            S_RUN:     state_nxt = S_RUN;
            default:   state_nxt = S_INIT;
        endcase
        if (reset)
            state_nxt = S_INIT;
    end

    // cpuReset comes straight from a flop so the CPU never sees a decode glitch.
    always_ff @(posedge clk) begin
        state     <= state_nxt;
        cpu_rst_q <= reset || (state_nxt != S_RUN);
        if (reset) begin
            loadCount  <= 9'd0;
            outPort    <= 8'd0;
            in_sync_p1 <= 8'd0;
            in_sync_p2 <= 8'd0;
        end else begin
            in_sync_p1 <= inPort;
            in_sync_p2 <= in_sync_p1;
            if (load_acc)
                loadCount <= count_inc;
            if (cpu_wr && (bus.memAdr == OUT_ADDR))
                outPort <= bus.memWD;
        end
    end

    // RAM is deliberately left out of reset so a loaded image survives it.
    always_ff @(posedge clk) begin
        if (load_acc)
            ram[loadCount[7:0]] <= bus.loadData;
        else if (cpu_wr)
            ram[bus.memAdr] <= bus.memWD;
    end

    assign bus.memRD = (bus.memAdr == IN_ADDR) ? in_sync_p2 : ram[bus.memAdr];
    assign cpuReset  = cpu_rst_q;

endmodule

// File: tb/tb_boot_memory.sv
// Directed bench for boot_memory: a PROG_LEN=4 instance and a PROG_LEN=256 instance.
module tb_boot_memory;

    logic       clk = 1'b0;
    logic       reset_a, reset_b;
    logic       cpu_rst_a, cpu_rst_b;
    logic [8:0] count_a, count_b;
    logic [7:0] in_a, in_b, out_a, out_b;
    int         total  = 0;
    int         passed = 0;
    int         failed = 0;
    logic [7:0] exp_data [4];

    boot_memory_if ifa ();
    boot_memory_if ifb ();

    boot_memory #(.PROG_LEN(4)) u_a (
        .clk(clk), .reset(reset_a), .bus(ifa.slave), .cpuReset(cpu_rst_a),
        .loadCount(count_a), .inPort(in_a), .outPort(out_a)
    );

    boot_memory #(.PROG_LEN(256)) u_b (
        .clk(clk), .reset(reset_b), .bus(ifb.slave), .cpuReset(cpu_rst_b),
        .loadCount(count_b), .inPort(in_b), .outPort(out_b)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        exp_data[0] = 8'h11; exp_data[1] = 8'h22; exp_data[2] = 8'h33; exp_data[3] = 8'h44;
        reset_a = 1'b1; reset_b = 1'b1; in_a = 8'h00; in_b = 8'h00;
        ifa.memEnable = 1'b0; ifa.memAdr = 8'h00; ifa.memWD = 8'h00;
        ifa.loadValid = 1'b0; ifa.loadData = 8'h00; ifa.loadDone = 1'b0;
        ifb.memEnable = 1'b0; ifb.memAdr = 8'h00; ifb.memWD = 8'h00;
        ifb.loadValid = 1'b0; ifb.loadData = 8'h00; ifb.loadDone = 1'b0;

        // Reset state
        cyc();
        chk("rst_cpuReset", 16'(cpu_rst_a), 16'h1);
        chk("rst_loadReady", 16'(ifa.loadReady), 16'h0);
        chk("rst_loadCount", 16'(count_a), 16'h0);
        chk("rst_outPort", 16'(out_a), 16'h0);
        reset_a = 1'b0; reset_b = 1'b0;
        #1;
        chk("load_ready_a", 16'(ifa.loadReady), 16'h1);
        chk("load_ready_b", 16'(ifb.loadReady), 16'h1);

        // Test 1: gapped 4-byte load
        for (int i = 0; i < 4; i++) begin
            ifa.loadValid = 1'b1; ifa.loadData = exp_data[i];
            #1;
            chk("t1_ready", 16'(ifa.loadReady), 16'h1);
            cyc();
            ifa.loadValid = 1'b0;
            chk("t1_count", 16'(count_a), 16'(i + 1));
            chk("t1_cpuReset", 16'(cpu_rst_a), 16'h1);
            if (i < 3) begin
                cyc();
                chk("t1_gap_count", 16'(count_a), 16'(i + 1));
            end
        end
        #1;
        chk("t1_release_ready", 16'(ifa.loadReady), 16'h0);
        chk("t1_release_cpuReset", 16'(cpu_rst_a), 16'h1);
        cyc();
        chk("t1_run_cpuReset", 16'(cpu_rst_a), 16'h0);
        chk("t1_run_ready", 16'(ifa.loadReady), 16'h0);
        for (int i = 0; i < 4; i++) begin
            ifa.memAdr = 8'(i);
            #1;
            chk("t1_ram", 16'(ifa.memRD), 16'(exp_data[i]));
        end

        // loadDone alone at count 0: empty load, RAM untouched
        reset_a = 1'b1;
        cyc();
        reset_a = 1'b0; ifa.loadDone = 1'b1;
        cyc();
        ifa.loadDone = 1'b0;
        chk("empty_count", 16'(count_a), 16'h0);
        chk("empty_release_cpuReset", 16'(cpu_rst_a), 16'h1);
        chk("empty_release_ready", 16'(ifa.loadReady), 16'h0);
        cyc();
        chk("empty_run_cpuReset", 16'(cpu_rst_a), 16'h0);
        ifa.memAdr = 8'h00;
        #1;
        chk("empty_ram0", 16'(ifa.memRD), 16'h11);

        // Test 6: full 256-byte load, byte i = i ^ A5
        for (int i = 0; i < 256; i++) begin
            ifb.loadValid = 1'b1; ifb.loadData = 8'(i) ^ 8'hA5;
            cyc();
        end
        chk("t6_count", 16'(count_b), 16'd256);
        chk("t6_release_cpuReset", 16'(cpu_rst_b), 16'h1);
        chk("t6_release_ready", 16'(ifb.loadReady), 16'h0);
        ifb.loadData = 8'h00;
        cyc();
        ifb.loadValid = 1'b0;
        chk("t6_run_cpuReset", 16'(cpu_rst_b), 16'h0);
        chk("t6_run_count", 16'(count_b), 16'd256);
        ifb.memAdr = 8'hFF;
        #1;
        chk("t6_ram255", 16'(ifb.memRD), 16'h5A);
        ifb.memAdr = 8'h00;
        #1;
        chk("t6_ram0", 16'(ifb.memRD), 16'hA5);

        // Test 3: CPU write to OUT_ADDR
        ifb.memEnable = 1'b1; ifb.memAdr = 8'hFF; ifb.memWD = 8'h5C;
        #1;
        chk("t3_old_read", 16'(ifb.memRD), 16'h5A);
        chk("t3_out_before", 16'(out_b), 16'h00);
        cyc();
        ifb.memEnable = 1'b0;
        #1;
        chk("t3_outPort", 16'(out_b), 16'h5C);
        chk("t3_new_read", 16'(ifb.memRD), 16'h5C);

        // Test 4: input synchronizer latency
        ifb.memAdr = 8'hFE;
        #1;
        chk("t4_initial", 16'(ifb.memRD), 16'h00);
        in_b = 8'h9E;
        cyc();
        chk("t4_edge1", 16'(ifb.memRD), 16'h00);
        cyc();
        chk("t4_edge2", 16'(ifb.memRD), 16'h9E);

        // Test 5: reset in RUN, then CPU write attempt during LOAD
        reset_b = 1'b1;
        cyc();
        chk("t5_cpuReset", 16'(cpu_rst_b), 16'h1);
        chk("t5_outPort", 16'(out_b), 16'h00);
        chk("t5_count", 16'(count_b), 16'h0);
        reset_b = 1'b0;
        #1;
        chk("t5_ready", 16'(ifb.loadReady), 16'h1);
        ifb.memEnable = 1'b1; ifb.memAdr = 8'h10; ifb.memWD = 8'h77;
        cyc();
        ifb.memEnable = 1'b0;
        #1;
        chk("t5_ram10_unchanged", 16'(ifb.memRD), 16'hB5);

        // Test 2: early end with loadDone on the third byte
        ifb.loadValid = 1'b1; ifb.loadData = 8'h01;
        cyc();
        chk("t2_count1", 16'(count_b), 16'h1);
        ifb.loadData = 8'h02;
        cyc();
        chk("t2_count2", 16'(count_b), 16'h2);
        ifb.loadData = 8'hAA; ifb.loadDone = 1'b1;
        cyc();
        ifb.loadValid = 1'b0; ifb.loadDone = 1'b0;
        chk("t2_count3", 16'(count_b), 16'h3);
        chk("t2_release_cpuReset", 16'(cpu_rst_b), 16'h1);
        chk("t2_release_ready", 16'(ifb.loadReady), 16'h0);
        cyc();
        chk("t2_run_cpuReset", 16'(cpu_rst_b), 16'h0);
        ifb.memAdr = 8'h02;
        #1;
        chk("t2_ram2", 16'(ifb.memRD), 16'hAA);
        ifb.memAdr = 8'h00;
        #1;
        chk("t2_ram0", 16'(ifb.memRD), 16'h01);
        ifb.memAdr = 8'h03;
        #1;
        chk("t2_ram3_kept", 16'(ifb.memRD), 16'hA6);
        ifb.memAdr = 8'hFF;
        #1;
        chk("t2_ramFF_kept", 16'(ifb.memRD), 16'h5C);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
